// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and debounces across whole frames.
// Latency: press accepted DEBOUNCE_SCANS frames after first sighting; frame = 4*SCAN_DIV clk cycles.
// Backpressure: none; key_valid is a single-cycle pulse that the consumer must take when it occurs.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   col_in     keypad columns, active-low, asynchronous to clk (synchronized internally)
//   row_out    row drive, active-low one-hot, registered
//   key_code   last accepted key {row_idx, col_idx}
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high while the accepted key is considered down
module keypad_scanner #(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Column synchronizer
    logic [3:0] r_col_meta;
    logic [3:0] r_col_sync;

    // Prescaler and row pointer
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_row_idx;

    // Frame accumulator: r_acc_cnt saturates at 2 meaning "two or more keys"
    logic [1:0] r_acc_cnt;
    logic [3:0] r_acc_key;

    // Debounce state
    state_t           r_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [3:0]       r_cand;

    logic       w_tick;
    logic       w_frame_end;
    logic [3:0] w_row_low;
    logic [2:0] w_row_cnt;
    logic [1:0] w_row_col;
    logic [2:0] w_sum;
    logic [1:0] w_frame_cnt;
    logic [3:0] w_frame_key;
    logic       w_none;
    logic       w_single;

    assign w_tick      = (r_div_cnt == DIV_MAX);
    assign w_frame_end = w_tick && (r_row_idx == 2'd3);
    assign w_row_low   = ~r_col_sync;

    // Per-row popcount and column index; the index only matters when exactly one bit is set.
    always_comb begin
        w_row_cnt = 3'd0;
        w_row_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (w_row_low[c]) begin
                w_row_cnt = w_row_cnt + 3'd1;
                w_row_col = 2'(c);
            end
        end
    end

    // Merge this row's sample into the frame so the frame-end decision includes the final row.
    always_comb begin
        w_sum       = {1'b0, r_acc_cnt} + w_row_cnt;
        w_frame_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_frame_key = (r_acc_cnt == 2'd0) ? {r_row_idx, w_row_col} : r_acc_key;
    end

    assign w_none   = (w_frame_cnt == 2'd0);
    assign w_single = (w_frame_cnt == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
        end else begin
            r_col_meta <= col_in;
            r_col_sync <= r_col_meta;
        end
    end

    // Row drive changes on the sampling edge, leaving the rest of the slot for settling
    // plus the two synchronizer stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_row_idx <= 2'd0;
            row_out   <= 4'b1110;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_row_idx <= r_row_idx + 2'd1;
                row_out   <= ~(4'b0001 << (r_row_idx + 2'd1));
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt <= 2'd0;
            r_acc_key <= 4'd0;
        end else if (w_tick) begin
            if (w_frame_end) begin
                r_acc_cnt <= 2'd0;
                r_acc_key <= 4'd0;
            end else begin
                r_acc_cnt <= w_frame_cnt;
                r_acc_key <= w_frame_key;
            end
        end
    end

    // Debounce FSM; advances only on frame-end edges. key_valid defaults low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_cand    <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    IDLE: begin
                        if (w_single) begin
                            r_cand    <= w_frame_key;
                            r_deb_cnt <= DEB_W'(1);
                            r_state   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_single && (w_frame_key == r_cand)) begin
                            if (r_deb_cnt + DEB_W'(1) >= DEB_MAX) begin
                                r_deb_cnt <= DEB_MAX;
                                r_state   <= PRESSED;
                                key_code  <= r_cand;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                            end
                        end else if (w_single) begin
                            r_cand    <= w_frame_key;
                            r_deb_cnt <= DEB_W'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        // Ghosting or another key while held is ignored; only a clean NONE starts release.
                        if (w_none) begin
                            r_deb_cnt <= DEB_W'(1);
                            r_state   <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (w_none) begin
                            if (r_deb_cnt + DEB_W'(1) >= DEB_MAX) begin
                                r_deb_cnt <= DEB_MAX;
                                r_state   <= IDLE;
                                key_held  <= 1'b0;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                            end
                        end else begin
                            r_state <= PRESSED;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural 4x4 keypad model.
// Latency: frame = 16 cycles with SCAN_DIV=4; presses accepted after 3 frames.
// Backpressure: none; pulses are counted per frame window.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;   // bit r*4+c set = key (r,c) held down

    int n_checks;
    int n_errors;
    int pulse_cnt;
    int held_low_cycles;
    logic [3:0] last_code;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n frames from a frame boundary, tallying key_valid cycles and key_held low cycles.
    task automatic run_frames(input int n);
        pulse_cnt       = 0;
        held_low_cycles = 0;
        repeat (n * 16) begin
            @(negedge clk);
            if (key_valid) begin
                pulse_cnt++;
                last_code = key_code;
            end
            if (!key_held) held_low_cycles++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_code = 4'd0;
        pressed   = 16'h0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_row", {28'd0, row_out}, 32'hE);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_held", {31'd0, key_held}, 32'd0);
        rst = 1'b0;

        // Row stepping over one empty frame
        repeat (4) @(negedge clk);
        chk("row1", {28'd0, row_out}, 32'hD);
        repeat (4) @(negedge clk);
        chk("row2", {28'd0, row_out}, 32'hB);
        repeat (4) @(negedge clk);
        chk("row3", {28'd0, row_out}, 32'h7);
        repeat (4) @(negedge clk);
        chk("row0_wrap", {28'd0, row_out}, 32'hE);

        // One-frame bounce of (2,1)
        pressed = 16'h1 << 9;
        run_frames(1);
        chk("bounce_press_pulse", pulse_cnt, 0);
        pressed = 16'h0;
        run_frames(3);
        chk("bounce_pulse", pulse_cnt, 0);
        chk("bounce_held", {31'd0, key_held}, 32'd0);

        // Clean press of (2,1): accepted exactly at the 3rd frame end
        pressed = 16'h1 << 9;
        run_frames(2);
        chk("press_early", pulse_cnt, 0);
        chk("press_early_held", {31'd0, key_held}, 32'd0);
        run_frames(1);
        chk("press_pulse", pulse_cnt, 1);
        chk("press_code", {28'd0, last_code}, 32'd9);
        chk("press_held", {31'd0, key_held}, 32'd1);
        run_frames(4);
        chk("hold_no_repeat", pulse_cnt, 0);
        chk("hold_held_low", held_low_cycles, 0);

        // One-frame release glitch keeps the key held
        pressed = 16'h0;
        run_frames(1);
        pressed = 16'h1 << 9;
        run_frames(2);
        chk("glitch_held_low", held_low_cycles, 0);
        chk("glitch_pulse", pulse_cnt, 0);

        // Real release: held drops on the 3rd NONE frame
        pressed = 16'h0;
        run_frames(2);
        chk("release_early_held_low", held_low_cycles, 0);
        run_frames(1);
        chk("release_held", {31'd0, key_held}, 32'd0);
        chk("release_code_kept", {28'd0, key_code}, 32'd9);

        // Re-press (0,3)
        pressed = 16'h1 << 3;
        run_frames(3);
        chk("repress_pulse", pulse_cnt, 1);
        chk("repress_code", {28'd0, last_code}, 32'd3);
        pressed = 16'h0;
        run_frames(3);
        chk("repress_release_held", {31'd0, key_held}, 32'd0);

        // Ghosting (1,1)+(2,2) never reports; dropping (2,2) yields (1,1)
        pressed = (16'h1 << 5) | (16'h1 << 10);
        run_frames(4);
        chk("multi_pulse", pulse_cnt, 0);
        chk("multi_held", {31'd0, key_held}, 32'd0);
        pressed = 16'h1 << 5;
        run_frames(2);
        chk("multi_drop_early", pulse_cnt, 0);
        run_frames(1);
        chk("multi_drop_pulse", pulse_cnt, 1);
        chk("multi_drop_code", {28'd0, last_code}, 32'd5);
        pressed = 16'h0;
        run_frames(3);
        chk("multi_release_held", {31'd0, key_held}, 32'd0);

        // Reset in the middle of debouncing (3,0)
        pressed = 16'h1 << 12;
        run_frames(1);
        repeat (8) @(negedge clk);
        chk("middeb_no_pulse", pulse_cnt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_row", {28'd0, row_out}, 32'hE);
        chk("midrst_code", {28'd0, key_code}, 32'd0);
        chk("midrst_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_held", {31'd0, key_held}, 32'd0);
        rst = 1'b0;
        run_frames(2);
        chk("postrst_early", pulse_cnt, 0);
        run_frames(1);
        chk("postrst_pulse", pulse_cnt, 1);
        chk("postrst_code", {28'd0, last_code}, 32'd12);
        chk("postrst_held", {31'd0, key_held}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
